// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding an RS232 transmitter, one byte in flight at a time.
// Defining UART_FEED_TIMEOUT_EN adds a WAIT timeout with a sticky oTMO flag.
module uart_tx_feeder #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int GAP_CLK = 4
`ifdef UART_FEED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 65535
`endif
) (
    input  logic              clk_s,
    input  logic              rst_s,
    input  logic              iWR,
    input  logic [7:0]        iWDATA,
    output logic              oFULL,
    output logic              oEMPTY,
    output logic [ADDR_W:0]   oCOUNT,
    output logic              oOVF,
    output logic              oSEND,
    output logic [7:0]        oTX_DATA,
    input  logic              iFINISH,
    output logic              oBUSY,
    output logic              oTMO
);
    localparam int GW = $clog2(GAP_CLK + 1);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;
    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic              send_q, send_d, busy_q, busy_d, tmo_q, tmo_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              push, pop, finish, expire;
`ifdef UART_FEED_TIMEOUT_EN
    logic [16:0]       wait_cnt_q, wait_cnt_d;
`endif
    always_comb begin
        push      = iWR && !full_q;
        pop       = state_q == LOAD && !empty_q;
        // a finish pulse coinciding with our own send pulse is left over from the previous byte
        finish    = iFINISH && !send_q;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d  = rd_ptr_q + ADDR_W'(pop);
        count_d   = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        full_d    = count_d == (ADDR_W+1)'(DEPTH);
        empty_d   = count_d == '0;
        ovf_d     = ovf_q || (iWR && full_q);
        tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
        gap_cnt_d = state_q == GAP ? gap_cnt_q + 1'b1 : '0;
`ifdef UART_FEED_TIMEOUT_EN
        wait_cnt_d = state_q == WAIT ? wait_cnt_q + 1'b1 : '0;
        expire     = state_q == WAIT && !finish && wait_cnt_q == 17'(TIMEOUT - 1);
        tmo_d      = tmo_q || expire;
`else
        expire     = 1'b0;
        tmo_d      = 1'b0;
`endif
        case (state_q)
            IDLE:    state_d = empty_q ? IDLE : LOAD;
            LOAD:    state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    state_d = finish || expire ? GAP : WAIT;
            GAP:     state_d = gap_cnt_q == GW'(GAP_CLK - 1) ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
        send_d = state_q == SEND;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            tx_data_q <= 8'hFF;
            gap_cnt_q <= '0;
`ifdef UART_FEED_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            if (push) mem_q[wr_ptr_q] <= iWDATA;
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            send_q    <= send_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
            tx_data_q <= tx_data_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef UART_FEED_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end
    assign oFULL    = full_q;
    assign oEMPTY   = empty_q;
    assign oCOUNT   = count_q;
    assign oOVF     = ovf_q;
    assign oSEND    = send_q;
    assign oTX_DATA = tx_data_q;
    assign oBUSY    = busy_q;
    assign oTMO     = tmo_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed scenarios plus random traffic against a timeline model of the feeder.
module tb_uart_tx_feeder;
    localparam int DEPTH = 16, ADDR_W = 4, G = 4, TMO = 100;
    logic clk_s = 1'b0, rst_s, iWR, iFINISH;
    logic [7:0] iWDATA;
    logic oFULL, oEMPTY, oOVF, oSEND, oBUSY, oTMO;
    logic [ADDR_W:0] oCOUNT;
    logic [7:0] oTX_DATA;
    always #5 clk_s = ~clk_s;
    uart_tx_feeder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CLK(G)
`ifdef UART_FEED_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk_s(clk_s), .rst_s(rst_s), .iWR(iWR), .iWDATA(iWDATA), .oFULL(oFULL),
        .oEMPTY(oEMPTY), .oCOUNT(oCOUNT), .oOVF(oOVF), .oSEND(oSEND),
        .oTX_DATA(oTX_DATA), .iFINISH(iFINISH), .oBUSY(oBUSY), .oTMO(oTMO)
    );
    int n_chk = 0, n_err = 0, t = 0, lat = 10, fin_at = -1;
    bit chk_en = 0, auto_fin = 0, force_fin = 0, rand_lat = 0;
    logic [7:0] q[$];
    logic [7:0] m_tx = 8'hFF;
    bit m_ovf = 0, m_tmo = 0, active = 0;
    int idle_at = 0, load_at = -1, send_at = -1;
    int snd_t[$];
    logic [7:0] snd_d[$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask
    // Model: FSM idle at cycle t with bytes queued -> pop at t+1, send pulse at t+3;
    // accepted finish at cycle c -> idle again at c+G+1.
    task automatic tick();
        int sz;
        bit idle_now, full_now, tmo_hit;
        iFINISH = force_fin || (auto_fin && t == fin_at);
        @(negedge clk_s);
        sz = q.size();
        if (chk_en) begin
            chk("count", oCOUNT, sz);
            chk("full", oFULL, sz == DEPTH);
            chk("empty", oEMPTY, sz == 0);
            chk("ovf", oOVF, m_ovf);
            chk("send", oSEND, active && t == send_at);
            chk("tx_data", oTX_DATA, m_tx);
            chk("busy", oBUSY, active || t < idle_at);
            chk("tmo", oTMO, m_tmo);
        end
        if (oSEND === 1'b1) begin
            snd_t.push_back(t);
            snd_d.push_back(oTX_DATA);
        end
        if (active && t == send_at) fin_at = t + (rand_lat ? int'($urandom_range(20, 1)) : lat);
        idle_now = !active && t >= idle_at;
        full_now = sz == DEPTH;
        tmo_hit = 0;
`ifdef UART_FEED_TIMEOUT_EN
        tmo_hit = active && t == send_at + TMO - 1 && !(iFINISH && t > send_at);
`endif
        if (rst_s) begin
            q.delete();
            m_ovf = 0; m_tmo = 0; active = 0;
            idle_at = t + 1; load_at = -1; send_at = -1; m_tx = 8'hFF;
        end else begin
            if ((active && t > send_at && iFINISH) || tmo_hit) begin
                active = 0;
                idle_at = t + G + 1;
                m_tmo = m_tmo || tmo_hit;
            end
            if (t == load_at) m_tx = q.pop_front();
            if (iWR) begin
                if (full_now) m_ovf = 1;
                else q.push_back(iWDATA);
            end
            if (idle_now && sz > 0) begin
                active = 1; load_at = t + 1; send_at = t + 3;
            end
        end
        @(posedge clk_s);
        #1;
        t++;
    endtask
    task automatic push(input logic [7:0] d);
        iWR = 1; iWDATA = d;
        tick();
        iWR = 0;
    endtask
    task automatic run(input int n);
        repeat (n) tick();
    endtask
    task automatic pulse_rst();
        rst_s = 1;
        tick();
        rst_s = 0;
    endtask
    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while ((oBUSY || !oEMPTY) && k < limit) begin
            tick();
            k++;
        end
        chk(tag, k < limit, 1);
    endtask
    initial begin
        int p, f, n0;
        rst_s = 1; iWR = 0; iWDATA = 0; iFINISH = 0;
        tick();
        rst_s = 0; chk_en = 1;
        chk("rst_tx", oTX_DATA, 8'hFF);
        chk("rst_empty", oEMPTY, 1);
        chk("rst_busy", oBUSY, 0);
        // single byte: send pulse 4 cycles after the push cycle
        auto_fin = 1; lat = 10;
        p = t;
        push(8'hA5);
        chk("t1_cnt", oCOUNT, 1);
        run(6);
        chk("t1_nsend", snd_t.size(), 1);
        if (snd_t.size() == 1) begin
            chk("t1_data", snd_d[0], 8'hA5);
            chk("t1_lat", snd_t[0] - p, 4);
        end
        wait_idle("t1_idle", 100);
        // back-to-back: finish sampled 50 edges after each send edge
        snd_t.delete(); snd_d.delete();
        lat = 49;
        push(8'h01); push(8'h02); push(8'h03);
        for (int k = 0; k < 500 && snd_t.size() < 3; k++) tick();
        chk("t2_nsend", snd_t.size(), 3);
        if (snd_t.size() == 3) begin
            chk("t2_d0", snd_d[0], 8'h01);
            chk("t2_d1", snd_d[1], 8'h02);
            chk("t2_d2", snd_d[2], 8'h03);
            chk("t2_gap01", snd_t[1] - snd_t[0], 50 + G + 3);
            chk("t2_gap12", snd_t[2] - snd_t[1], 50 + G + 3);
        end
        wait_idle("t2_idle", 300);
        // fill: 17 pushes with the first byte stuck in flight, then an overflowing push
        auto_fin = 0;
        for (int i = 0; i < 17; i++) push(8'($urandom_range(255, 0)));
        chk("t3_full", oFULL, 1);
        chk("t3_cnt", oCOUNT, DEPTH);
        chk("t3_ovf0", oOVF, 0);
        push(8'hEE);
        chk("t3_ovf", oOVF, 1);
        chk("t3_cnt2", oCOUNT, DEPTH);
        // full with a push landing on the LOAD cycle: push rejected, pop happens
        pulse_rst();
        for (int i = 0; i < 17; i++) push(8'($urandom_range(255, 0)));
        chk("t4_ovf0", oOVF, 0);
        force_fin = 1; f = t;
        tick();
        force_fin = 0;
        while (t < f + G + 2) tick();
        push(8'h5A);
        chk("t4_cnt", oCOUNT, DEPTH - 1);
        chk("t4_ovf", oOVF, 1);
        chk("t4_full", oFULL, 0);
        auto_fin = 1; rand_lat = 1;
        wait_idle("t4_drain", 2000);
        // reset in WAIT with 5 bytes queued
        auto_fin = 0;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        run(6);
        chk("t5_cnt", oCOUNT, 5);
        chk("t5_busy", oBUSY, 1);
        pulse_rst();
        chk("t5_cnt0", oCOUNT, 0);
        chk("t5_empty", oEMPTY, 1);
        chk("t5_ovf", oOVF, 0);
        chk("t5_tx", oTX_DATA, 8'hFF);
        chk("t5_busy0", oBUSY, 0);
        chk("t5_send", oSEND, 0);
        n0 = snd_t.size();
        force_fin = 1;
        tick();
        force_fin = 0;
        run(30);
        chk("t5_nosend", snd_t.size(), n0);
        // no finish at all
        push(8'h77); push(8'h78);
        run(300);
`ifdef UART_FEED_TIMEOUT_EN
        chk("t6_tmo", oTMO, 1);
        chk("t6_nsend", snd_t.size(), n0 + 2);
`else
        chk("t6_tmo", oTMO, 0);
        chk("t6_busy", oBUSY, 1);
        chk("t6_nsend", snd_t.size(), n0 + 1);
`endif
        force_fin = 1;
        tick();
        force_fin = 0;
        auto_fin = 1;
        wait_idle("t6_idle", 500);
        // random traffic, including stray finish pulses and occasional resets
        repeat (1500) begin
            iWR = $urandom_range(9, 0) < 4;
            iWDATA = 8'($urandom_range(255, 0));
            force_fin = $urandom_range(19, 0) == 0;
            rst_s = $urandom_range(499, 0) == 0;
            tick();
        end
        iWR = 0; force_fin = 0; rst_s = 0;
        wait_idle("rand_idle", 2000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
